// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART TX write-port arbiter.
package uart_tx_arbiter_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Width of a counter that must be able to hold the value max_len.
  function automatic int cnt_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams on one side and the FIFO write port on the other.
// The arbiter uses the master view; the requesters and the FIFO use the slave view.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  import uart_tx_arbiter_pkg::*;

  logic [N_REQ-1:0]        req_valid;
  logic [BYTE_W*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]        req_last;
  logic [N_REQ-1:0]        req_ready;
  logic [BYTE_W-1:0]       fifo_din;
  logic                    fifo_wr_en;
  logic                    fifo_full;
  logic [N_REQ-1:0]        grant;
  logic                    trunc_pulse;

  modport master (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_din, fifo_wr_en, grant, trunc_pulse
  );

  modport slave (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_din, fifo_wr_en, grant, trunc_pulse
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit strictly after ptr,
// searching upward and wrapping, so the last winner has the lowest priority.
module rr_pick_n #(
  parameter  int n = 4,
  localparam int W = (n > 1) ? $clog2(n) : 1
) (
  input  logic [n-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [n-1:0] onehot,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [W-1:0] cand;

  // Walk the candidates ptr+1, ptr+2, ... and keep the first one that requests.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = '0;
    for (int k = 1; k <= n; k++) begin
      cand = W'((int'(ptr) + k) % n);
      if (!any && req[cand]) begin
        any          = 1'b1;
        idx          = cand;
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares the TX byte FIFO write port among N_REQ
// requesters. One requester owns the port for a whole message (or until the
// per-grant byte limit), so messages never interleave inside the FIFO.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int MAX_LEN = 16
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.master bus
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = cnt_width(MAX_LEN);
  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(MAX_LEN - 1);

  state_t            state;
  logic [N_REQ-1:0]  grant_q;
  logic [IDX_W-1:0]  owner_q;
  logic [IDX_W-1:0]  ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              trunc_q;

  logic [N_REQ-1:0]  pick_onehot;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;

  logic [BYTE_W-1:0] req_bytes [N_REQ];
  logic [N_REQ-1:0]  ready_c;
  logic [BYTE_W-1:0] din_c;
  logic              wr_en_c;
  logic              owner_last;
  logic              at_limit;

  rr_pick_n #(.n(N_REQ)) u_pick (
    .req    (bus.req_valid),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign at_limit = (count_q == LIMIT);

  // Route the owner's byte and handshake to the FIFO; everything stays quiet while idle.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_bytes[i] = bus.req_data[i*BYTE_W +: BYTE_W];
    end
    ready_c    = '0;
    din_c      = '0;
    wr_en_c    = 1'b0;
    owner_last = 1'b0;
    if (state == ST_BUSY) begin
      ready_c[owner_q] = !bus.fifo_full;
      din_c            = req_bytes[owner_q];
      wr_en_c          = bus.req_valid[owner_q] && !bus.fifo_full;
      owner_last       = bus.req_last[owner_q];
    end
  end

  // Grant FSM: pick an owner while idle, count its bytes, release on last byte or at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= PTR_RST;
      count_q <= '0;
      trunc_q <= 1'b0;
    end else begin
      trunc_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            grant_q <= pick_onehot;
            owner_q <= pick_idx;
            count_q <= '0;
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (wr_en_c) begin
            if (owner_last || at_limit) begin
              state   <= ST_IDLE;
              grant_q <= '0;
              ptr_q   <= owner_q;
              count_q <= '0;
              trunc_q <= !owner_last;
            end else begin
              count_q <= count_q + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready   = ready_c;
  assign bus.fifo_din    = din_c;
  assign bus.fifo_wr_en  = wr_en_c;
  assign bus.grant       = grant_q;
  assign bus.trunc_pulse = trunc_q;

endmodule
